// File: rtl/sifive_dcsr_pkg.sv
// Shared types for the dcsr controller: field layout, debug-entry causes,
// controller states and privilege encodings.
package sifive_dcsr_pkg;

   localparam logic [1:0] PRV_U = 2'd0;
   localparam logic [1:0] PRV_S = 2'd1;
   localparam logic [1:0] PRV_H = 2'd2;   // reserved encoding, never stored
   localparam logic [1:0] PRV_M = 2'd3;

   typedef enum logic [2:0] {
      CAUSE_NONE      = 3'd0,
      CAUSE_EBREAK    = 3'd1,
      CAUSE_TRIGGER   = 3'd2,
      CAUSE_HALTREQ   = 3'd3,
      CAUSE_STEP      = 3'd4,
      CAUSE_RESETHALT = 3'd5
   } cause_e;

   typedef enum logic [1:0] {
      ST_RUN        = 2'd0,
      ST_STEP_ARMED = 2'd1,
      ST_STEP_PEND  = 2'd2,
      ST_HALTED     = 2'd3
   } state_e;

   typedef struct packed {
      logic [1:0]  xdebugver;
      logic [1:0]  zero4;
      logic [11:0] zero3;
      logic        ebreakm;
      logic        ebreakh;
      logic        ebreaks;
      logic        ebreaku;
      logic        zero2;
      logic        stopcycle;
      logic        stoptime;
      logic [2:0]  cause;
      logic [2:0]  zero1;
      logic        step;
      logic [1:0]  prv;
   } dcsr_t;

   // An ebreak only enters debug when the ebreak bit for the current privilege is set.
   function automatic logic ebreak_enabled(input logic [1:0] prv,
                                           input logic       em,
                                           input logic       es,
                                           input logic       eu);
      logic en;
      case (prv)
         PRV_M:   en = em;
         PRV_S:   en = es;
         PRV_U:   en = eu;
         default: en = 1'b0;
      endcase
      return en;
   endfunction

endpackage

// File: rtl/sifive_dcsr_cause_arb.sv
// Combinational qualification and priority selection of debug-entry causes.
// Priority: trigger > ebreak > resethaltreq > haltreq > completed single step.
module sifive_dcsr_cause_arb
   import sifive_dcsr_pkg::*;
(
   input  logic [1:0] cur_prv,
   input  logic       halted,
   input  logic       step_pend,
   input  logic       ev_trigger,
   input  logic       ev_ebreak,
   input  logic       ev_haltreq,
   input  logic       ev_resethaltreq,
   input  logic       ebreakm,
   input  logic       ebreaks,
   input  logic       ebreaku,
   output logic       enter,
   output logic [2:0] cause
);

   logic ebreak_q;

   assign ebreak_q = ev_ebreak & ebreak_enabled(cur_prv, ebreakm, ebreaks, ebreaku);

   // Pick the highest-priority entry cause; nothing enters while already halted.
   always_comb begin
      enter = 1'b0;
      cause = CAUSE_NONE;
      if (halted) begin
         enter = 1'b0;
         cause = CAUSE_NONE;
      end else if (ev_trigger) begin
         enter = 1'b1;
         cause = CAUSE_TRIGGER;
      end else if (ebreak_q) begin
         enter = 1'b1;
         cause = CAUSE_EBREAK;
      end else if (ev_resethaltreq) begin
         enter = 1'b1;
         cause = CAUSE_RESETHALT;
      end else if (ev_haltreq) begin
         enter = 1'b1;
         cause = CAUSE_HALTREQ;
      end else if (step_pend) begin
         enter = 1'b1;
         cause = CAUSE_STEP;
      end else begin
         enter = 1'b0;
         cause = CAUSE_NONE;
      end
   end

endmodule

// File: rtl/sifive_dcsr_ctrl.sv
// dcsr owner for one hart: debug entry, dret exit, single-step sequencing and
// the flat dcsr field bus. Optional build macro SIFIVE_DCSR_STOPCOUNT_EN makes
// stoptime/stopcycle writable; without it both fields are constant zero.
module sifive_dcsr_ctrl
   import sifive_dcsr_pkg::*;
#(
   parameter logic [1:0] XDEBUGVER = 2'd1
)(
   input  logic        clock,
   input  logic        reset_n,
   input  logic [1:0]  cur_prv,
   input  logic        ev_trigger,
   input  logic        ev_ebreak,
   input  logic        ev_haltreq,
   input  logic        ev_resethaltreq,
   input  logic        insn_retire,
   input  logic        dret_valid,
   input  logic        csr_wen,
   input  logic [31:0] csr_wdata,
   output logic [31:0] csr_rdata,
   output logic        enter_debug,
   output logic        debug_mode,
   output logic [1:0]  ret_prv,
   output logic        stop_time,
   output logic        stop_cycle,
   output logic [1:0]  dcsr_prv,
   output logic        dcsr_step,
   output logic [2:0]  dcsr_cause,
   output logic        dcsr_stoptime,
   output logic        dcsr_stopcycle,
   output logic        dcsr_ebreaku,
   output logic        dcsr_ebreaks,
   output logic        dcsr_ebreakh,
   output logic        dcsr_ebreakm,
   output logic [1:0]  dcsr_xdebugver
);

   state_e     state_r, state_nxt;
   logic [1:0] prv_r, prv_nxt, prv_wr_s;
   logic       step_r, step_nxt;
   logic [2:0] cause_r, cause_nxt;
   logic       ebreakm_r, ebreakh_r, ebreaks_r, ebreaku_r;
   logic       ebreakm_nxt, ebreakh_nxt, ebreaks_nxt, ebreaku_nxt;
   logic       stoptime_r, stopcycle_r;
   logic       halted_s, step_pend_s, wr_s, enter_s;
   logic [2:0] arb_cause_s;
   logic       unused_s;
   dcsr_t      dcsr_s;

   assign halted_s    = (state_r == ST_HALTED);
   assign step_pend_s = (state_r == ST_STEP_PEND);
   assign wr_s        = csr_wen & halted_s;
   // The reserved privilege encoding is dropped so prv always holds a legal mode.
   assign prv_wr_s    = (csr_wdata[1:0] != PRV_H) ? csr_wdata[1:0] : prv_r;

   sifive_dcsr_cause_arb u_arb (
      .cur_prv         (cur_prv),
      .halted          (halted_s),
      .step_pend       (step_pend_s),
      .ev_trigger      (ev_trigger),
      .ev_ebreak       (ev_ebreak),
      .ev_haltreq      (ev_haltreq),
      .ev_resethaltreq (ev_resethaltreq),
      .ebreakm         (ebreakm_r),
      .ebreaks         (ebreaks_r),
      .ebreaku         (ebreaku_r),
      .enter           (enter_s),
      .cause           (arb_cause_s)
   );

   // Next values of the architectural fields: entry latches cause/prv, halted writes update the rest.
   always_comb begin
      prv_nxt     = prv_r;
      step_nxt    = step_r;
      cause_nxt   = cause_r;
      ebreakm_nxt = ebreakm_r;
      ebreakh_nxt = ebreakh_r;
      ebreaks_nxt = ebreaks_r;
      ebreaku_nxt = ebreaku_r;
      if (enter_s) begin
         cause_nxt = arb_cause_s;
         prv_nxt   = cur_prv;
      end else if (wr_s) begin
         prv_nxt     = prv_wr_s;
         step_nxt    = csr_wdata[2];
         ebreaku_nxt = csr_wdata[12];
         ebreaks_nxt = csr_wdata[13];
         ebreakh_nxt = csr_wdata[14];
         ebreakm_nxt = csr_wdata[15];
      end else begin
         prv_nxt  = prv_r;
         step_nxt = step_r;
      end
   end

   // Controller state sequencing; a same-cycle write decides the dret target through step_nxt.
   always_comb begin
      state_nxt = state_r;
      if (enter_s) begin
         state_nxt = ST_HALTED;
      end else begin
         case (state_r)
            ST_HALTED: begin
               if (dret_valid) begin
                  state_nxt = step_nxt ? ST_STEP_ARMED : ST_RUN;
               end else begin
                  state_nxt = ST_HALTED;
               end
            end
            ST_STEP_ARMED: begin
               if (insn_retire) begin
                  state_nxt = ST_STEP_PEND;
               end else begin
                  state_nxt = ST_STEP_ARMED;
               end
            end
            ST_STEP_PEND: state_nxt = ST_STEP_PEND;  // arbiter always enters from here
            ST_RUN:       state_nxt = ST_RUN;
            default:      state_nxt = ST_RUN;
         endcase
      end
   end

   // Controller state register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= ST_RUN;
      end else begin
         state_r <= state_nxt;
      end
   end

   // Architectural dcsr field registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         prv_r     <= PRV_M;
         step_r    <= 1'b0;
         cause_r   <= CAUSE_NONE;
         ebreakm_r <= 1'b0;
         ebreakh_r <= 1'b0;
         ebreaks_r <= 1'b0;
         ebreaku_r <= 1'b0;
      end else begin
         prv_r     <= prv_nxt;
         step_r    <= step_nxt;
         cause_r   <= cause_nxt;
         ebreakm_r <= ebreakm_nxt;
         ebreakh_r <= ebreakh_nxt;
         ebreaks_r <= ebreaks_nxt;
         ebreaku_r <= ebreaku_nxt;
      end
   end

`ifdef SIFIVE_DCSR_STOPCOUNT_EN
   // Stop-count control bits, writable only while halted.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stoptime_r  <= 1'b0;
         stopcycle_r <= 1'b0;
      end else if (wr_s) begin
         stoptime_r  <= csr_wdata[9];
         stopcycle_r <= csr_wdata[10];
      end else begin
         stoptime_r  <= stoptime_r;
         stopcycle_r <= stopcycle_r;
      end
   end
   assign unused_s = ^{csr_wdata[31:16], csr_wdata[11], csr_wdata[8:3]};
`else
   assign stoptime_r  = 1'b0;
   assign stopcycle_r = 1'b0;
   assign unused_s    = ^{csr_wdata[31:16], csr_wdata[11:3]};
`endif

   // Pack the architectural view; reserved fields read as zero.
   always_comb begin
      dcsr_s           = dcsr_t'(32'd0);
      dcsr_s.xdebugver = XDEBUGVER;
      dcsr_s.ebreakm   = ebreakm_r;
      dcsr_s.ebreakh   = ebreakh_r;
      dcsr_s.ebreaks   = ebreaks_r;
      dcsr_s.ebreaku   = ebreaku_r;
      dcsr_s.stopcycle = stopcycle_r;
      dcsr_s.stoptime  = stoptime_r;
      dcsr_s.cause     = cause_r;
      dcsr_s.step      = step_r;
      dcsr_s.prv       = prv_r;
   end

   assign csr_rdata      = dcsr_s;
   assign enter_debug    = enter_s;
   assign debug_mode     = halted_s;
   // A write in the dret cycle already supplies the privilege to return to.
   assign ret_prv        = wr_s ? prv_wr_s : prv_r;
   assign stop_time      = halted_s & stoptime_r;
   assign stop_cycle     = halted_s & stopcycle_r;
   assign dcsr_prv       = prv_r;
   assign dcsr_step      = step_r;
   assign dcsr_cause     = cause_r;
   assign dcsr_stoptime  = stoptime_r;
   assign dcsr_stopcycle = stopcycle_r;
   assign dcsr_ebreaku   = ebreaku_r;
   assign dcsr_ebreaks   = ebreaks_r;
   assign dcsr_ebreakh   = ebreakh_r;
   assign dcsr_ebreakm   = ebreakm_r;
   assign dcsr_xdebugver = XDEBUGVER;

endmodule
